uart_tx_scheduler: RTL and testbench

- Round-robin scheduler that shares one UART byte transmitter between NREQ message requesters (event reporters such as the "Done" ASCII sender, time/status printers).
- Grants one requester for a whole message and forwards its bytes one at a time using the transmitter's start/done handshake.
- Guards every byte with a tx_done timeout and returns the port to idle if the transmitter hangs.
- Sits between the requester blocks and the UART TX core.

---
 rtl/uart_sched_pkg.sv | 20 ++
 rtl/uart_tx_scheduler_rr_pick.sv | 25 ++
 rtl/uart_tx_scheduler.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_sched_pkg.sv
// Shared constants for the UART TX scheduler: FSM encoding and default sizing.
package uart_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } sched_state_e;

  localparam int DEF_NREQ    = 4;
  localparam int DEF_TIMEOUT = 20000;
  localparam int DEF_TW      = 15;

  // Ring successor of idx among n slots.
  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_pick.sv
// Round-robin picker: first set request found walking the ring from i_ptr.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [PW-1:0]   o_idx,
  output logic            o_any
);

  logic [PW-1:0] w_slot;

  // Scan from the farthest slot back to i_ptr so the nearest request is the last written.
  always_comb begin
    o_idx  = '0;
    w_slot = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_slot = PW'((int'(i_ptr) + k) % NREQ);
      if (i_req[w_slot]) o_idx = w_slot;
    end
    o_any = |i_req;
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART byte transmitter among NREQ message requesters, one whole
// message per grant, with a per-byte tx_done watchdog.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int TW      = DEF_TW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   gnt,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_done,
  output logic              busy,
  output logic              err_timeout
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  sched_state_e r_state, w_state_nxt;

  logic [PW-1:0]   r_rr_ptr, r_owner;
  logic            r_last;
  logic [TW-1:0]   r_timer;
  logic [NREQ-1:0] r_gnt, r_req_ready;
  logic [7:0]      r_tx_data;
  logic            r_tx_start, r_busy, r_err;

  logic [PW-1:0]   w_rr_ptr_nxt, w_owner_nxt;
  logic            w_last_nxt;
  logic [TW-1:0]   w_timer_nxt;
  logic [NREQ-1:0] w_gnt_nxt, w_req_ready_nxt;
  logic [7:0]      w_tx_data_nxt;
  logic            w_tx_start_nxt, w_err_nxt;

  logic [NREQ-1:0][7:0] w_bytes;
  logic [NREQ-1:0]      w_req_eff;
  logic [PW-1:0]        w_pick, w_next_ptr;
  logic                 w_any, w_timeout, w_hold_go;

  assign w_bytes = req_data;

  // A requester still shows its consumed byte during its req_ready cycle, so
  // its valid is not trusted until the pulse has gone.
  assign w_req_eff  = req_valid & ~r_req_ready;
  assign w_hold_go  = w_req_eff[r_owner];
  assign w_timeout  = (r_timer == TW'(TIMEOUT - 1));
  assign w_next_ptr = PW'(next_idx(int'(r_owner), NREQ));

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .i_req (w_req_eff),
    .i_ptr (r_rr_ptr),
    .o_idx (w_pick),
    .o_any (w_any)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; tx_done outside WAIT is ignored, and beats the timeout inside it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_any) w_state_nxt = ST_SEND;
      ST_SEND: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (tx_done)        w_state_nxt = r_last ? ST_IDLE : ST_HOLD;
        else if (w_timeout) w_state_nxt = ST_IDLE;
      end
      ST_HOLD: if (w_hold_go) w_state_nxt = ST_SEND;
    endcase
  end

  // Output/datapath next values; pulses default low, everything else holds.
  always_comb begin
    w_rr_ptr_nxt    = r_rr_ptr;
    w_owner_nxt     = r_owner;
    w_last_nxt      = r_last;
    w_gnt_nxt       = r_gnt;
    w_tx_data_nxt   = r_tx_data;
    w_timer_nxt     = r_timer;
    w_tx_start_nxt  = 1'b0;
    w_req_ready_nxt = '0;
    w_err_nxt       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_owner_nxt    = w_pick;
          w_gnt_nxt      = NREQ'(1) << w_pick;
          w_tx_data_nxt  = w_bytes[w_pick];
          w_last_nxt     = req_last[w_pick];
          w_tx_start_nxt = 1'b1;
        end
      end
      ST_SEND: w_timer_nxt = '0;
      ST_WAIT: begin
        w_timer_nxt = r_timer + TW'(1);
        if (tx_done) begin
          w_req_ready_nxt = r_gnt;
          if (r_last) begin
            w_gnt_nxt    = '0;
            w_rr_ptr_nxt = w_next_ptr;
          end
        end else if (w_timeout) begin
          w_err_nxt    = 1'b1;
          w_gnt_nxt    = '0;
          w_rr_ptr_nxt = w_next_ptr;
        end
      end
      ST_HOLD: begin
        if (w_hold_go) begin
          w_tx_data_nxt  = w_bytes[r_owner];
          w_last_nxt     = req_last[r_owner];
          w_tx_start_nxt = 1'b1;
        end
      end
    endcase
  end

  // Registered outputs and datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_last      <= 1'b0;
      r_gnt       <= '0;
      r_tx_data   <= 8'h00;
      r_timer     <= '0;
      r_tx_start  <= 1'b0;
      r_req_ready <= '0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_owner     <= w_owner_nxt;
      r_last      <= w_last_nxt;
      r_gnt       <= w_gnt_nxt;
      r_tx_data   <= w_tx_data_nxt;
      r_timer     <= w_timer_nxt;
      r_tx_start  <= w_tx_start_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_err       <= w_err_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
    end
  end

  assign req_ready   = r_req_ready;
  assign gnt         = r_gnt;
  assign tx_start    = r_tx_start;
  assign tx_data     = r_tx_data;
  assign busy        = r_busy;
  assign err_timeout = r_err;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: requester models feed messages, a transmitter
// model answers tx_start, and a scoreboard queue holds the expected byte order.
module tb_uart_tx_scheduler;

  localparam int NREQ = 4;
  localparam int TMO  = 16;
  localparam int DLY  = 10;

  logic              clk, rst;
  logic [NREQ-1:0]   req_valid, req_last, req_ready, gnt;
  logic [8*NREQ-1:0] req_data;
  logic              tx_start, tx_done, busy, err_timeout;
  logic [7:0]        tx_data;

  uart_tx_scheduler #(.NREQ(NREQ), .TIMEOUT(TMO), .TW(15)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .gnt(gnt),
    .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
    .busy(busy), .err_timeout(err_timeout)
  );

  typedef struct packed { logic [1:0] r; logic [7:0] d; } exp_t;
  typedef struct packed {
    int pre; logic [3:0] mask; int len; int n; logic [3:0][1:0] ord;
  } vec_t;

  int   n_vec, n_err, cyc, done_dly, n_start, err_cnt, start_cyc;
  bit   glitch;
  exp_t sb[$];
  logic [7:0] mbuf [NREQ][8];
  int   mlen[NREQ], mpos[NREQ], rdy_cnt[NREQ], exp_rdy[NREQ];
  vec_t tbl[8];

  initial begin clk = 0; forever #5 clk = ~clk; end
  initial begin cyc = 0; forever begin @(posedge clk); cyc++; end end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(int pre, logic [3:0] mask, int len, int n,
                              int o0, int o1, int o2, int o3);
    vec_t t;
    t.pre = pre; t.mask = mask; t.len = len; t.n = n;
    t.ord[0] = 2'(o0); t.ord[1] = 2'(o1); t.ord[2] = 2'(o2); t.ord[3] = 2'(o3);
    return t;
  endfunction

  function automatic logic [7:0] vb(int v, int r, int b);
    return 8'(16 * (v + 1) + 4 * r + b);
  endfunction

  function automatic bit pending();
    for (int i = 0; i < NREQ; i++) if (mpos[i] < mlen[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic load(input int r, input int len, input logic [7:0] b0, b1, b2, b3);
    mbuf[r][0] = b0; mbuf[r][1] = b1; mbuf[r][2] = b2; mbuf[r][3] = b3;
    mpos[r] = 0; mlen[r] = len; exp_rdy[r] += len;
  endtask

  task automatic push(input int r, input logic [7:0] d);
    exp_t e;
    e.r = 2'(r); e.d = d;
    sb.push_back(e);
  endtask

  task automatic clear_cnt();
    n_start = 0; err_cnt = 0;
    for (int i = 0; i < NREQ; i++) begin rdy_cnt[i] = 0; exp_rdy[i] = 0; end
  endtask

  task automatic drop_msgs();
    for (int i = 0; i < NREQ; i++) begin mlen[i] = 0; mpos[i] = 0; end
  endtask

  task automatic do_reset();
    rst = 1; drop_msgs(); sb.delete();
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, " gnt"}, gnt, 0);        chk({nm, " req_ready"}, req_ready, 0);
    chk({nm, " tx_start"}, tx_start, 0); chk({nm, " tx_data"}, tx_data, 0);
    chk({nm, " busy"}, busy, 0);      chk({nm, " err_timeout"}, err_timeout, 0);
  endtask

  task automatic drain(input string nm);
    int k = 0;
    while ((pending() || busy || sb.size() != 0) && k < 3000) begin
      @(negedge clk); k++;
    end
    repeat (2) @(negedge clk);
    chk({nm, " drained"}, 32'(k < 3000), 1);
    chk({nm, " sb_left"}, sb.size(), 0);
    chk({nm, " gnt_idle"}, gnt, 0);
    chk({nm, " busy_idle"}, busy, 0);
    for (int i = 0; i < NREQ; i++)
      chk($sformatf("%s rdy[%0d]", nm, i), rdy_cnt[i], exp_rdy[i]);
  endtask

  // Requester models: present the head byte, advance on req_ready.
  initial begin
    req_valid = '0; req_data = '0; req_last = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i] && mpos[i] < mlen[i]) mpos[i]++;
        if (mpos[i] < mlen[i]) begin
          req_valid[i] = 1'b1;
          req_data[8*i +: 8] = mbuf[i][mpos[i]];
          req_last[i] = (mpos[i] == mlen[i] - 1);
        end else begin
          req_valid[i] = 1'b0; req_data[8*i +: 8] = 8'h00; req_last[i] = 1'b0;
        end
      end
    end
  end

  // Transmitter model: tx_done done_dly cycles after tx_start (never if 0);
  // with glitch set it also raises tx_done in the tx_start cycle and the req_ready cycle.
  initial begin
    int cnt;
    cnt = 0; tx_done = 0;
    forever begin
      @(negedge clk);
      tx_done = 0;
      if (rst) cnt = 0;
      else begin
        if (cnt > 0) begin cnt--; if (cnt == 0) tx_done = 1; end
        if (tx_start) begin
          if (done_dly > 0) cnt = done_dly;
          if (glitch) tx_done = 1;
        end
        if (glitch && |req_ready) tx_done = 1;
      end
    end
  end

  // Monitor: scoreboard pop on tx_start, req_ready latency and counts, err pulses.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (tx_start) begin
          n_start++; start_cyc = cyc;
          if (sb.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL sb_extra: tx_start with data %0h, none expected", tx_data);
          end else begin
            e = sb.pop_front();
            chk("tx_data", tx_data, e.d);
            chk("tx_gnt", gnt, 32'(1) << e.r);
          end
        end
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) begin
          rdy_cnt[i]++;
          if (done_dly > 0) chk("rdy_latency", cyc - start_cyc, done_dly + 1);
        end
        if (err_timeout) err_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit, %0d vectors so far", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, s;
    n_vec = 0; n_err = 0; done_dly = DLY; glitch = 0; start_cyc = 0;
    rst = 1; drop_msgs(); clear_cnt();
    // rr order table: pre-message sets rr_ptr, then all masked requesters race.
    tbl[0] = mk(-1, 4'b0101, 2, 2, 0, 2, 0, 0);
    tbl[1] = mk( 2, 4'b1010, 1, 2, 3, 1, 0, 0);
    tbl[2] = mk(-1, 4'b1010, 1, 2, 3, 1, 0, 0);
    tbl[3] = mk(-1, 4'b1111, 1, 4, 2, 3, 0, 1);
    tbl[4] = mk( 3, 4'b1001, 1, 2, 0, 3, 0, 0);
    tbl[5] = mk(-1, 4'b1000, 2, 1, 3, 0, 0, 0);
    tbl[6] = mk(-1, 4'b0110, 2, 2, 1, 2, 0, 0);
    tbl[7] = mk(-1, 4'b0011, 1, 2, 0, 1, 0, 0);

    repeat (3) @(negedge clk);
    chk_reset_outs("reset");
    rst = 0;

    // "Done" from requester 0.
    clear_cnt();
    load(0, 4, 8'h44, 8'h6F, 8'h6E, 8'h65);
    push(0, 8'h44); push(0, 8'h6F); push(0, 8'h6E); push(0, 8'h65);
    drain("done");
    chk("done starts", n_start, 4);

    // rr_ptr is now 1: requester 1 goes before requester 0.
    clear_cnt();
    load(1, 1, 8'h31, 0, 0, 0); load(0, 1, 8'h30, 0, 0, 0);
    push(1, 8'h31); push(0, 8'h30);
    drain("ptr1");

    do_reset();
    for (int v = 0; v < 8; v++) begin
      clear_cnt();
      if (tbl[v].pre >= 0) begin
        load(tbl[v].pre, 1, 8'hF0 + 8'(tbl[v].pre), 0, 0, 0);
        push(tbl[v].pre, 8'hF0 + 8'(tbl[v].pre));
        drain($sformatf("vec%0d pre", v));
      end
      for (int r = 0; r < NREQ; r++)
        if (tbl[v].mask[r]) load(r, tbl[v].len, vb(v, r, 0), vb(v, r, 1), vb(v, r, 2), vb(v, r, 3));
      for (int q = 0; q < tbl[v].n; q++)
        for (int b = 0; b < tbl[v].len; b++) push(int'(tbl[v].ord[q]), vb(v, int'(tbl[v].ord[q]), b));
      drain($sformatf("vec%0d", v));
    end

    // Timeout: no tx_done for requester 0's byte.
    do_reset(); clear_cnt(); done_dly = 0;
    load(0, 1, 8'hA0, 0, 0, 0); load(1, 1, 8'hA1, 0, 0, 0);
    push(0, 8'hA0);
    k = 0; while (!tx_start && k < 50) begin @(negedge clk); k++; end
    chk("to start seen", 32'(k < 50), 1);
    s = cyc;
    k = 0; while (!err_timeout && k < 100) begin @(negedge clk); k++; end
    chk("to latency", cyc - s, TMO + 1);
    chk("to gnt", gnt, 0);
    chk("to req_ready", req_ready, 0);
    done_dly = DLY;
    push(1, 8'hA1); push(0, 8'hA0);
    @(negedge clk);
    chk("to next gnt", gnt, 4'b0010);
    drain("timeout");
    chk("to err count", err_cnt, 1);

    // Reset during WAIT of byte 2 from requester 2 (rr_ptr had moved to 2).
    clear_cnt();
    load(1, 1, 8'hC1, 0, 0, 0); push(1, 8'hC1);
    drain("rst pre");
    clear_cnt();
    load(2, 3, 8'hD0, 8'hD1, 8'hD2, 0); push(2, 8'hD0); push(2, 8'hD1);
    k = 0; while (n_start < 2 && k < 200) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    rst = 1; drop_msgs(); exp_rdy[2] = 1;
    @(negedge clk);
    chk_reset_outs("midrst");
    chk("midrst sb", sb.size(), 0);
    rst = 0;
    load(3, 1, 8'hE3, 0, 0, 0); load(1, 1, 8'hE1, 0, 0, 0);
    push(1, 8'hE1); push(3, 8'hE3);
    drain("rst post");

    // Stray tx_done in the tx_start cycle and in HOLD.
    clear_cnt(); glitch = 1;
    load(0, 2, 8'h5A, 8'hA5, 0, 0); push(0, 8'h5A); push(0, 8'hA5);
    drain("glitch");
    glitch = 0;
    chk("glitch starts", n_start, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
